// File: rtl/dmi_initiator_if.sv
// dmi_initiator_if: toggle-handshake DMI bus between the DTM initiator and the debug module
interface dmi_initiator_if;
  logic         dmi_start;
  logic [1:0]   dmi_op;
  logic [33:2]  dmi_data_o;
  logic [40:34] dmi_address;
  logic         dmi_finish;
  logic [33:2]  dmi_data_i;
  modport master (
    output dmi_start, dmi_op, dmi_data_o, dmi_address,
    input  dmi_finish, dmi_data_i
  );
  modport slave (
    input  dmi_start, dmi_op, dmi_data_o, dmi_address,
    output dmi_finish, dmi_data_i
  );
endinterface

// File: rtl/dmi_initiator.sv
// dmi_initiator: DTM-side toggle-handshake DMI initiator with dtmcs sticky status; optional WAIT timeout under DMI_TIMEOUT_EN
module dmi_initiator #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_data,
  input  logic        dmireset,
  input  logic        dmihardreset,
  output logic        rsp_valid,
  output logic [1:0]  rsp_op,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [1:0]  sticky,
  dmi_initiator_if.master dmi
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [1:0] ST_OK = 2'd0, ST_FAIL = 2'd2, ST_BUSY = 2'd3;
  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_op_q, rsp_op_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  sticky_q, sticky_d;
  logic        fin_s1_q, fin_s2_q;
  logic        equal;
`ifdef DMI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
  // finish toggle arrives from another domain; a late toggle shows up as unequal levels
  assign equal = fin_s2_q == start_q;
  // state, DMI request registers, response and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      op_q        <= 2'd0;
      addr_q      <= 7'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= 2'd0;
      rsp_data_q  <= 32'd0;
      sticky_q    <= 2'd0;
      fin_s1_q    <= 1'b0;
      fin_s2_q    <= 1'b0;
`ifdef DMI_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      sticky_q    <= sticky_d;
      fin_s1_q    <= dmi.dmi_finish;
      fin_s2_q    <= fin_s1_q;
`ifdef DMI_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  // next state: issue/reject in IDLE, completion (or timeout) in WAIT, one-cycle response in RESP
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    sticky_d    = sticky_q;
`ifdef DMI_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (sticky_q != ST_OK) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_op_d    = sticky_q;
          end else if (req_op == 2'd0 || req_op == 2'd3) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_op_d    = ST_OK;
          end else if (!equal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_op_d    = ST_BUSY;
            sticky_d    = ST_BUSY;
          end else begin
            state_d = S_WAIT;
            start_d = ~start_q;
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_data;
`ifdef DMI_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (req_valid && sticky_q == ST_OK) sticky_d = ST_BUSY;
        if (equal) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_op_d    = ST_OK;
          rsp_data_d  = dmi.dmi_data_i;
        end
`ifdef DMI_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_op_d    = ST_FAIL;
          sticky_d    = ST_FAIL;
        end else cnt_d = cnt_q + CW'(1);
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (req_valid && sticky_q == ST_OK) sticky_d = ST_BUSY;
      end
      default: state_d = S_IDLE;
    endcase
    if (dmihardreset) begin
      state_d     = S_IDLE;
      start_d     = start_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_op_d    = rsp_op_q;
      rsp_data_d  = rsp_data_q;
      sticky_d    = ST_OK;
    end
    if (dmireset) sticky_d = ST_OK;
  end
  assign rsp_valid       = rsp_valid_q;
  assign rsp_op          = rsp_op_q;
  assign rsp_data        = rsp_data_q;
  assign sticky          = sticky_q;
  assign busy            = (state_q != S_IDLE) || !equal;
  assign dmi.dmi_start   = start_q;
  assign dmi.dmi_op      = op_q;
  assign dmi.dmi_address = addr_q;
  assign dmi.dmi_data_o  = wdata_q;
endmodule

// File: tb/tb_dmi_initiator.sv
// tb_dmi_initiator: directed scoreboard bench for dmi_initiator; timeout scenario only when DMI_TIMEOUT_EN is defined
module tb_dmi_initiator;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [6:0]  req_addr = 7'd0;
  logic [31:0] req_data = 32'd0;
  logic        dmireset = 1'b0;
  logic        dmihardreset = 1'b0;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_data;
  logic        busy;
  logic [1:0]  sticky;
  logic [31:0] cyc = 32'd0;
  logic [31:0] n0 = 32'd0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  dmi_initiator_if dmi();
  dmi_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .dmireset(dmireset),
    .dmihardreset(dmihardreset), .rsp_valid(rsp_valid), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .busy(busy), .sticky(sticky), .dmi(dmi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic req(input logic [1:0] o, input logic [6:0] a, input logic [31:0] d);
    @(posedge clk); #1 req_valid = 1'b1; req_op = o; req_addr = a; req_data = d;
    @(posedge clk); #1 req_valid = 1'b0; n0 = cyc;
  endtask
  task automatic expect_rsp(input logic [1:0] o, input logic [31:0] d, input int off);
    exp_t e;
    e.op = o; e.data = d; e.cyc = n0 + off;
    sb.push_back(e);
  endtask
  task automatic respond(input int k, input logic [31:0] d);
    repeat (k) @(posedge clk);
    #1 dmi.dmi_finish = ~dmi.dmi_finish; dmi.dmi_data_i = d;
  endtask
  task automatic pulse(input logic hard);
    @(posedge clk); #1 if (hard) dmihardreset = 1'b1; else dmireset = 1'b1;
    @(posedge clk); #1 dmihardreset = 1'b0; dmireset = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sticky"}, 32'(sticky), 32'd0);
    chk({tag, "_start"}, 32'(dmi.dmi_start), 32'd0);
    chk({tag, "_op"}, 32'(dmi.dmi_op), 32'd0);
    chk({tag, "_addr"}, 32'(dmi.dmi_address), 32'd0);
    chk({tag, "_wdata"}, dmi.dmi_data_o, 32'd0);
  endtask
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp got op=%0d data=%h want none", rsp_op, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_op", 32'(rsp_op), 32'(mon_e.op));
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    dmi.dmi_finish = 1'b0;
    dmi.dmi_data_i = 32'd0;
    idle(2);
    chk_zero("reset");
    rst_n = 1'b1;
    req(2'd2, 7'h10, 32'h8000_0001);
    expect_rsp(2'd0, 32'h1234_5678, 8);
    chk("wr_start", 32'(dmi.dmi_start), 32'd1);
    chk("wr_busy", 32'(busy), 32'd1);
    respond(5, 32'h1234_5678);
    chk("wr_addr", 32'(dmi.dmi_address), 32'h10);
    chk("wr_data", dmi.dmi_data_o, 32'h8000_0001);
    chk("wr_op", 32'(dmi.dmi_op), 32'd2);
    idle(4);
    chk("wr_idle_busy", 32'(busy), 32'd0);
    req(2'd1, 7'h11, 32'd0);
    expect_rsp(2'd0, 32'h0000_0382, 7);
    respond(4, 32'h0000_0382);
    idle(4);
    chk("rd_start_back", 32'(dmi.dmi_start), 32'd0);
    req(2'd0, 7'h05, 32'hFFFF_FFFF);
    expect_rsp(2'd0, 32'h0000_0382, 0);
    idle(1);
    chk("nop_start", 32'(dmi.dmi_start), 32'd0);
    req(2'd3, 7'h06, 32'h1);
    expect_rsp(2'd0, 32'h0000_0382, 0);
    idle(1);
    chk("rsv_start", 32'(dmi.dmi_start), 32'd0);
    req(2'd2, 7'h20, 32'hAAAA_5555);
    expect_rsp(2'd0, 32'h0000_0055, 7);
    req(2'd1, 7'h21, 32'd0);
    chk("ovl_start", 32'(dmi.dmi_start), 32'd1);
    chk("ovl_sticky", 32'(sticky), 32'd3);
    chk("ovl_busy", 32'(busy), 32'd1);
    respond(2, 32'h0000_0055);
    idle(4);
    req(2'd1, 7'h22, 32'd0);
    expect_rsp(2'd3, 32'h0000_0055, 0);
    chk("rej_start", 32'(dmi.dmi_start), 32'd1);
    chk("rej_op", 32'(dmi.dmi_op), 32'd2);
    pulse(1'b0);
    chk("clr_sticky", 32'(sticky), 32'd0);
    req(2'd1, 7'h12, 32'd0);
    expect_rsp(2'd0, 32'h0BAD_F00D, 6);
    chk("rd2_start", 32'(dmi.dmi_start), 32'd0);
    respond(3, 32'h0BAD_F00D);
    idle(4);
    req(2'd2, 7'h21, 32'h1);
    pulse(1'b1);
    chk("hr_busy", 32'(busy), 32'd1);
    chk("hr_sticky", 32'(sticky), 32'd0);
    req(2'd1, 7'h30, 32'd0);
    expect_rsp(2'd3, 32'h0BAD_F00D, 0);
    chk("late_sticky", 32'(sticky), 32'd3);
    chk("late_start", 32'(dmi.dmi_start), 32'd1);
    respond(1, 32'hFFFF_0000);
    idle(4);
    chk("late_eq_busy", 32'(busy), 32'd0);
    pulse(1'b0);
    req(2'd1, 7'h13, 32'd0);
    expect_rsp(2'd0, 32'h0000_0077, 5);
    respond(2, 32'h0000_0077);
    idle(4);
`ifdef DMI_TIMEOUT_EN
    req(2'd2, 7'h14, 32'h0000_CAFE);
    expect_rsp(2'd2, 32'h0000_0077, 16);
    idle(17);
    chk("to_sticky", 32'(sticky), 32'd2);
    req(2'd1, 7'h15, 32'd0);
    expect_rsp(2'd2, 32'h0000_0077, 0);
    respond(1, 32'h0000_1111);
    idle(4);
    pulse(1'b0);
    chk("to_clr", 32'(sticky), 32'd0);
    req(2'd2, 7'h15, 32'h1);
    expect_rsp(2'd0, 32'h0000_0099, 5);
    respond(2, 32'h0000_0099);
    idle(4);
`endif
    req(2'd2, 7'h16, 32'h2);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0; dmi.dmi_finish = 1'b0; dmi.dmi_data_i = 32'd0;
    #1 chk_zero("midrst");
    idle(2);
    rst_n = 1'b1;
    req(2'd1, 7'h17, 32'd0);
    expect_rsp(2'd0, 32'h0000_3C3C, 6);
    chk("post_rst_start", 32'(dmi.dmi_start), 32'd1);
    respond(3, 32'h0000_3C3C);
    idle(6);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
